// File: rtl/dest_sel_pkg.sv
// ----------------------------------------------------------------------------
// dest_sel_pkg
// Shared constants for the destination-register select pipeline.
//   REG_W     : width of an architectural register index
//   REG_ZERO  : register index that is hard-wired to zero
//   REG_RA    : return-address register index
//   DSEL_*    : select encodings for the usual candidate order rt / rd / $ra
//   is_pow2   : helper used to decide whether a select can ever be out of range
// ----------------------------------------------------------------------------
package dest_sel_pkg;

    localparam int REG_W = 5;

    localparam logic [REG_W-1:0] REG_ZERO = 5'd0;
    localparam logic [REG_W-1:0] REG_RA   = 5'd31;

    localparam int DSEL_RT = 0;
    localparam int DSEL_RD = 1;
    localparam int DSEL_RA = 2;

    // A binary select covering exactly 2**n inputs can never point past the
    // last candidate, so the out-of-range detector collapses to a constant.
    function automatic bit is_pow2(input int n);
        return (n > 0) && ((n & (n - 1)) == 0);
    endfunction

endpackage

// File: rtl/dest_sel_pipe_if.sv
// ----------------------------------------------------------------------------
// dest_sel_pipe_if
// Bundles the candidate/select/control inputs and the per-stage results of
// dest_sel_pipe.
//   master : the ID stage / hazard logic driving candidates and controls
//   slave  : the pipeline itself
// Signals:
//   in_flat [NUM_IN*WIDTH]  candidate i at [i*WIDTH +: WIDTH]
//   sel     [SEL_W]         candidate index
//   in_vld, stall, flush    issue valid, load-use stall, branch flush
//   src_a, src_b [WIDTH]    rs / rt of the instruction in ID
//   dst_q [STAGES*WIDTH], vld_q [STAGES]   registered stage contents
//   wb_dst, wb_vld          last-stage destination and valid
//   hit_a, hit_b [STAGES]   per-stage hazard matches
//   bad_sel                 sticky out-of-range select flag
// With DEST_SEL_PERF_CNT_EN defined, wb_cnt and bubble_cnt [15:0] are added.
// ----------------------------------------------------------------------------
interface dest_sel_pipe_if
    import dest_sel_pkg::*;
#(
    parameter int WIDTH  = REG_W,
    parameter int NUM_IN = 3,
    parameter int STAGES = 3
);

    localparam int SEL_W = $clog2(NUM_IN);

    logic [NUM_IN*WIDTH-1:0] in_flat;
    logic [SEL_W-1:0]        sel;
    logic                    in_vld;
    logic                    stall;
    logic                    flush;
    logic [WIDTH-1:0]        src_a;
    logic [WIDTH-1:0]        src_b;

    logic [STAGES*WIDTH-1:0] dst_q;
    logic [STAGES-1:0]       vld_q;
    logic [WIDTH-1:0]        wb_dst;
    logic                    wb_vld;
    logic [STAGES-1:0]       hit_a;
    logic [STAGES-1:0]       hit_b;
    logic                    bad_sel;

`ifdef DEST_SEL_PERF_CNT_EN
    logic [15:0]             wb_cnt;
    logic [15:0]             bubble_cnt;

    modport master (
        output in_flat, sel, in_vld, stall, flush, src_a, src_b,
        input  dst_q, vld_q, wb_dst, wb_vld, hit_a, hit_b, bad_sel,
        input  wb_cnt, bubble_cnt
    );

    modport slave (
        input  in_flat, sel, in_vld, stall, flush, src_a, src_b,
        output dst_q, vld_q, wb_dst, wb_vld, hit_a, hit_b, bad_sel,
        output wb_cnt, bubble_cnt
    );
`else
    modport master (
        output in_flat, sel, in_vld, stall, flush, src_a, src_b,
        input  dst_q, vld_q, wb_dst, wb_vld, hit_a, hit_b, bad_sel
    );

    modport slave (
        input  in_flat, sel, in_vld, stall, flush, src_a, src_b,
        output dst_q, vld_q, wb_dst, wb_vld, hit_a, hit_b, bad_sel
    );
`endif

endinterface

// File: rtl/dest_sel_mux.sv
// ----------------------------------------------------------------------------
// dest_sel_mux
// Purely combinational NUM_IN x WIDTH multiplexer with out-of-range detect.
//   in_flat      in  candidates, candidate i at [i*WIDTH +: WIDTH]
//   sel          in  candidate index
//   mux_out      out selected candidate (candidate 0 when sel is out of range)
//   out_of_range out high when sel >= NUM_IN
// ----------------------------------------------------------------------------
module dest_sel_mux
    import dest_sel_pkg::*;
#(
    parameter int WIDTH  = REG_W,
    parameter int NUM_IN = 3
) (
    input  logic [NUM_IN*WIDTH-1:0]     in_flat,
    input  logic [$clog2(NUM_IN)-1:0]   sel,
    output logic [WIDTH-1:0]            mux_out,
    output logic                        out_of_range
);

    // Candidate 0 is the default, so an out-of-range select falls back to it
    // without a separate correction step.
    always_comb begin
        mux_out = in_flat[WIDTH-1:0];
        for (int i = 1; i < NUM_IN; i++) begin
            if (int'(sel) == i) begin
                mux_out = in_flat[i*WIDTH +: WIDTH];
            end
        end
    end

    // A power-of-two candidate count fills the select range exactly.
    generate
        if (is_pow2(NUM_IN)) begin : g_full_range
            assign out_of_range = 1'b0;
        end else begin : g_partial_range
            assign out_of_range = (int'(sel) >= NUM_IN);
        end
    endgenerate

endmodule

// File: rtl/dest_sel_pipe.sv
// ----------------------------------------------------------------------------
// dest_sel_pipe
// Selects a destination register from NUM_IN candidates and carries it, with
// a valid bit, through STAGES pipeline registers (ID/EX, EX/MEM, MEM/WB...).
// Stall and flush insert bubbles; per-stage hazard vectors feed forwarding.
// Ports:
//   Clk    in  rising-edge clock
//   Reset  in  synchronous, active-high reset
//   bus    dest_sel_pipe_if.slave (candidates, controls, stage outputs)
// Parameters: WIDTH, NUM_IN, STAGES, ZERO_SUPPRESS (dst 0 never hits).
// Optional: define DEST_SEL_PERF_CNT_EN to add saturating 16-bit wb_cnt and
// bubble_cnt counters on the interface.
// ----------------------------------------------------------------------------
module dest_sel_pipe
    import dest_sel_pkg::*;
#(
    parameter int WIDTH         = REG_W,
    parameter int NUM_IN        = 3,
    parameter int STAGES        = 3,
    parameter int ZERO_SUPPRESS = 1
) (
    input  logic            Clk,
    input  logic            Reset,
    dest_sel_pipe_if.slave  bus
);

    logic [WIDTH-1:0]  mux_out;
    logic              sel_bad;
    logic [WIDTH-1:0]  dst_r [STAGES];
    logic [STAGES-1:0] vld_r;
    logic              bad_sel_r;

    dest_sel_mux #(
        .WIDTH  (WIDTH),
        .NUM_IN (NUM_IN)
    ) u_mux (
        .in_flat      (bus.in_flat),
        .sel          (bus.sel),
        .mux_out      (mux_out),
        .out_of_range (sel_bad)
    );

    // Stage registers. Flush beats stall for stage 0 (bubble rather than
    // hold); stage 1 takes a bubble whenever stall is high, which also covers
    // the flush+stall case. Later stages always shift. bad_sel only latches
    // when the bad select is actually captured into stage 0.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int k = 0; k < STAGES; k++) begin
                dst_r[k] <= '0;
            end
            vld_r     <= '0;
            bad_sel_r <= 1'b0;
        end else begin
            if (bus.flush) begin
                dst_r[0] <= '0;
                vld_r[0] <= 1'b0;
            end else if (!bus.stall) begin
                dst_r[0] <= mux_out;
                vld_r[0] <= bus.in_vld;
            end

            if (bus.stall) begin
                dst_r[1] <= '0;
                vld_r[1] <= 1'b0;
            end else begin
                dst_r[1] <= dst_r[0];
                vld_r[1] <= vld_r[0];
            end

            for (int k = 2; k < STAGES; k++) begin
                dst_r[k] <= dst_r[k-1];
                vld_r[k] <= vld_r[k-1];
            end

            if (bus.in_vld && sel_bad && !bus.stall && !bus.flush) begin
                bad_sel_r <= 1'b1;
            end
        end
    end

    // Flatten the stage contents and compare each valid stage against the
    // two source registers. Register zero is never a real dependency when
    // ZERO_SUPPRESS is set, so it is masked out of both hit vectors.
    always_comb begin
        bus.dst_q = '0;
        bus.hit_a = '0;
        bus.hit_b = '0;
        for (int k = 0; k < STAGES; k++) begin
            bus.dst_q[k*WIDTH +: WIDTH] = dst_r[k];
            bus.hit_a[k] = vld_r[k] && (dst_r[k] == bus.src_a) &&
                           !((ZERO_SUPPRESS != 0) && (dst_r[k] == '0));
            bus.hit_b[k] = vld_r[k] && (dst_r[k] == bus.src_b) &&
                           !((ZERO_SUPPRESS != 0) && (dst_r[k] == '0));
        end
    end

    assign bus.vld_q   = vld_r;
    assign bus.wb_dst  = dst_r[STAGES-1];
    assign bus.wb_vld  = vld_r[STAGES-1];
    assign bus.bad_sel = bad_sel_r;

`ifdef DEST_SEL_PERF_CNT_EN
    logic [15:0] wb_cnt_r;
    logic [15:0] bubble_cnt_r;

    // Saturating event counters: retired valid writebacks, and edges on which
    // stall and/or flush injected a bubble (one count per edge).
    always_ff @(posedge Clk) begin
        if (Reset) begin
            wb_cnt_r     <= '0;
            bubble_cnt_r <= '0;
        end else begin
            if (vld_r[STAGES-1] && (wb_cnt_r != 16'hFFFF)) begin
                wb_cnt_r <= wb_cnt_r + 16'd1;
            end
            if ((bus.stall || bus.flush) && (bubble_cnt_r != 16'hFFFF)) begin
                bubble_cnt_r <= bubble_cnt_r + 16'd1;
            end
        end
    end

    assign bus.wb_cnt     = wb_cnt_r;
    assign bus.bubble_cnt = bubble_cnt_r;
`endif

endmodule

// File: tb/tb_dest_sel_pipe.sv
// ----------------------------------------------------------------------------
// tb_dest_sel_pipe
// Directed bench for dest_sel_pipe with default parameters (WIDTH=5,
// NUM_IN=3, STAGES=3, ZERO_SUPPRESS=1). Inputs change 1ns after a rising
// edge and outputs are sampled there too. Stage states in the comments use
// {dst,vld} notation, stage 0 first.
// ----------------------------------------------------------------------------
module tb_dest_sel_pipe;
    import dest_sel_pkg::*;

    localparam int WIDTH  = 5;
    localparam int NUM_IN = 3;
    localparam int STAGES = 3;
    localparam int SEL_W  = 2;

    logic clk;
    logic reset;
    int   vectors;
    int   miscompares;

    dest_sel_pipe_if #(
        .WIDTH  (WIDTH),
        .NUM_IN (NUM_IN),
        .STAGES (STAGES)
    ) bus ();

    dest_sel_pipe #(
        .WIDTH         (WIDTH),
        .NUM_IN        (NUM_IN),
        .STAGES        (STAGES),
        .ZERO_SUPPRESS (1)
    ) dut (
        .Clk   (clk),
        .Reset (reset),
        .bus   (bus)
    );

    // Free-running 10ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Drive select and control inputs for the next edge.
    task automatic applyStimulus(input logic [SEL_W-1:0] sel_v, input logic vld_v,
                                 input logic stall_v, input logic flush_v);
        bus.sel    = sel_v;
        bus.in_vld = vld_v;
        bus.stall  = stall_v;
        bus.flush  = flush_v;
    endtask

    // Load the rt / rd / $ra candidates.
    task automatic setCandidates(input logic [4:0] rt, input logic [4:0] rd, input logic [4:0] ra);
        bus.in_flat = {ra, rd, rt};
    endtask

    // Advance one edge and settle past it.
    task automatic stepClock();
        @(posedge clk);
        #1;
    endtask

    // Directed sequence; each block states the stage contents it expects.
    initial begin
        vectors     = 0;
        miscompares = 0;

        // Reset dominates even with a valid issue on the inputs.
        reset = 1'b1;
        setCandidates(5'd8, 5'd9, REG_RA);
        applyStimulus(2'(DSEL_RD), 1'b1, 1'b0, 1'b0);
        bus.src_a = 5'd0;
        bus.src_b = 5'd0;
        stepClock();
        stepClock();
        checkOutput("rst_vld_q",   32'(bus.vld_q),   32'h0);
        checkOutput("rst_dst_q",   32'(bus.dst_q),   32'h0);
        checkOutput("rst_wb_dst",  32'(bus.wb_dst),  32'h0);
        checkOutput("rst_wb_vld",  32'(bus.wb_vld),  32'h0);
        checkOutput("rst_hit_a",   32'(bus.hit_a),   32'h0);
        checkOutput("rst_hit_b",   32'(bus.hit_b),   32'h0);
        checkOutput("rst_bad_sel", 32'(bus.bad_sel), 32'h0);

        // One idle edge, then issue rd=9 once; it retires after exactly 3 edges.
        reset = 1'b0;
        applyStimulus(2'(DSEL_RT), 1'b0, 1'b0, 1'b0);
        stepClock();
        applyStimulus(2'(DSEL_RD), 1'b1, 1'b0, 1'b0);
        stepClock();
        checkOutput("issue_vld_q", 32'(bus.vld_q),      32'h1);
        checkOutput("issue_dst0",  32'(bus.dst_q[4:0]), 32'd9);
        checkOutput("issue_wb_vld_0", 32'(bus.wb_vld),  32'h0);
        applyStimulus(2'(DSEL_RT), 1'b0, 1'b0, 1'b0);
        for (int c = 1; c <= 3; c++) begin
            stepClock();
            checkOutput($sformatf("issue_wb_vld_%0d", c), 32'(bus.wb_vld), (c == 2) ? 32'h1 : 32'h0);
            if (c == 2) begin
                checkOutput("issue_wb_dst", 32'(bus.wb_dst), 32'd9);
            end
        end

        // Stall: issue rt=8, then two stall edges with a different valid issue
        // that must not be captured. Stage 1 is a bubble during the stall.
        applyStimulus(2'(DSEL_RT), 1'b1, 1'b0, 1'b0);
        stepClock();
        applyStimulus(2'(DSEL_RD), 1'b1, 1'b1, 1'b0);
        for (int s = 0; s < 2; s++) begin
            stepClock();
            checkOutput($sformatf("stall_vld1_%0d", s), 32'(bus.vld_q[1]),   32'h0);
            checkOutput($sformatf("stall_dst1_%0d", s), 32'(bus.dst_q[9:5]), 32'h0);
            checkOutput($sformatf("stall_vld0_%0d", s), 32'(bus.vld_q[0]),   32'h1);
            checkOutput($sformatf("stall_dst0_%0d", s), 32'(bus.dst_q[4:0]), 32'd8);
            checkOutput($sformatf("stall_wb_%0d", s),   32'(bus.wb_vld),     32'h0);
        end
        applyStimulus(2'(DSEL_RT), 1'b0, 1'b0, 1'b0);
        stepClock();
        checkOutput("stall_release_vld_q", 32'(bus.vld_q),  32'h2);
        checkOutput("stall_release_wb",    32'(bus.wb_vld), 32'h0);
        stepClock();
        checkOutput("stall_wb_vld", 32'(bus.wb_vld), 32'h1);
        checkOutput("stall_wb_dst", 32'(bus.wb_dst), 32'd8);

        // Flush with stall: {31,1} {9,1} {8,0} -> {0,0} {0,0} {9,1}.
        applyStimulus(2'(DSEL_RD), 1'b1, 1'b0, 1'b0);
        stepClock();
        applyStimulus(2'(DSEL_RA), 1'b1, 1'b0, 1'b0);
        stepClock();
        applyStimulus(2'(DSEL_RT), 1'b1, 1'b1, 1'b1);
        stepClock();
        checkOutput("fs_vld_q",  32'(bus.vld_q),  32'h4);
        checkOutput("fs_dst_q",  32'(bus.dst_q),  32'({5'd9, 5'd0, 5'd0}));
        checkOutput("fs_wb_dst", 32'(bus.wb_dst), 32'd9);
        applyStimulus(2'(DSEL_RT), 1'b0, 1'b0, 1'b0);
        stepClock();
        checkOutput("fs_drain_vld_q",  32'(bus.vld_q),  32'h0);
        checkOutput("fs_drain_wb_dst", 32'(bus.wb_dst), 32'h0);

        // Flush only: {9,1} {8,0} {0,0} -> {0,0} {9,1} {8,0}.
        applyStimulus(2'(DSEL_RD), 1'b1, 1'b0, 1'b0);
        stepClock();
        applyStimulus(2'(DSEL_RA), 1'b1, 1'b0, 1'b1);
        stepClock();
        checkOutput("flush_vld_q", 32'(bus.vld_q), 32'h2);
        checkOutput("flush_dst_q", 32'(bus.dst_q), 32'({5'd8, 5'd9, 5'd0}));

        // Hazard: after two edges stages are {8,0} {8,1} {0,0}.
        applyStimulus(2'(DSEL_RT), 1'b1, 1'b0, 1'b0);
        stepClock();
        applyStimulus(2'(DSEL_RT), 1'b0, 1'b0, 1'b0);
        stepClock();
        bus.src_a = 5'd8;
        bus.src_b = 5'd0;
        #1;
        checkOutput("haz_hit_a", 32'(bus.hit_a), 32'h2);
        checkOutput("haz_hit_b", 32'(bus.hit_b), 32'h0);
        bus.src_a = 5'd9;
        #1;
        checkOutput("haz_hit_a_miss", 32'(bus.hit_a), 32'h0);
        bus.src_a = 5'd8;

        // Valid dst 0 in stage 0: {0,1} {8,0} {8,1}; zero never hits.
        setCandidates(5'd0, 5'd9, REG_RA);
        applyStimulus(2'(DSEL_RT), 1'b1, 1'b0, 1'b0);
        stepClock();
        checkOutput("haz_zero_hit_a", 32'(bus.hit_a), 32'h4);
        checkOutput("haz_zero_hit_b", 32'(bus.hit_b), 32'h0);

        // Two more 8s: {8,1} {8,1} {0,1} -> multiple hits on src_a.
        setCandidates(5'd8, 5'd9, REG_RA);
        stepClock();
        stepClock();
        checkOutput("haz_multi_hit_a", 32'(bus.hit_a),  32'h3);
        checkOutput("haz_multi_hit_b", 32'(bus.hit_b),  32'h0);
        checkOutput("haz_zero_wb_vld", 32'(bus.wb_vld), 32'h1);
        checkOutput("haz_zero_wb_dst", 32'(bus.wb_dst), 32'h0);

        // Bad select: only a captured valid issue with sel=3 sets the flag.
        checkOutput("bad_pre", 32'(bus.bad_sel), 32'h0);
        setCandidates(5'd4, 5'd9, REG_RA);
        applyStimulus(2'd3, 1'b1, 1'b1, 1'b0);
        stepClock();
        checkOutput("bad_stalled", 32'(bus.bad_sel), 32'h0);
        applyStimulus(2'd3, 1'b1, 1'b0, 1'b1);
        stepClock();
        checkOutput("bad_flushed", 32'(bus.bad_sel), 32'h0);
        applyStimulus(2'd3, 1'b0, 1'b0, 1'b0);
        stepClock();
        checkOutput("bad_invalid",      32'(bus.bad_sel),    32'h0);
        checkOutput("bad_invalid_dst0", 32'(bus.dst_q[4:0]), 32'd4);
        applyStimulus(2'd3, 1'b1, 1'b0, 1'b0);
        stepClock();
        checkOutput("bad_set",  32'(bus.bad_sel),    32'h1);
        checkOutput("bad_dst0", 32'(bus.dst_q[4:0]), 32'd4);
        checkOutput("bad_vld0", 32'(bus.vld_q[0]),   32'h1);
        applyStimulus(2'(DSEL_RD), 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            stepClock();
        end
        checkOutput("bad_sticky", 32'(bus.bad_sel), 32'h1);
        bus.src_a = 5'd9;
        #1;
        checkOutput("full_hit_a", 32'(bus.hit_a), 32'h7);

        // Reset with a full pipeline discards everything in flight.
        reset = 1'b1;
        stepClock();
        checkOutput("midrst_vld_q",   32'(bus.vld_q),   32'h0);
        checkOutput("midrst_dst_q",   32'(bus.dst_q),   32'h0);
        checkOutput("midrst_hit_a",   32'(bus.hit_a),   32'h0);
        checkOutput("midrst_wb_vld",  32'(bus.wb_vld),  32'h0);
        checkOutput("midrst_bad_sel", 32'(bus.bad_sel), 32'h0);

`ifdef DEST_SEL_PERF_CNT_EN
        // Counters: 4 stall edges + 1 stall+flush edge = 5 bubbles, then a
        // long valid run saturates the writeback counter.
        checkOutput("perf_rst_wb",     32'(bus.wb_cnt),     32'h0);
        checkOutput("perf_rst_bubble", 32'(bus.bubble_cnt), 32'h0);
        reset = 1'b0;
        applyStimulus(2'(DSEL_RT), 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            stepClock();
        end
        applyStimulus(2'(DSEL_RT), 1'b0, 1'b1, 1'b1);
        stepClock();
        checkOutput("perf_bubble_5", 32'(bus.bubble_cnt), 32'd5);
        checkOutput("perf_wb_0",     32'(bus.wb_cnt),     32'h0);
        applyStimulus(2'(DSEL_RT), 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 70000; i++) begin
            stepClock();
        end
        checkOutput("perf_wb_sat",    32'(bus.wb_cnt),     32'hFFFF);
        checkOutput("perf_bubble_eq", 32'(bus.bubble_cnt), 32'd5);
`endif

        reset = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/dest_sel_pipe.md
Name: dest_sel_pipe

Overview:
Parametrised successor to the 5-bit destination-register mux. It selects one of NUM_IN candidate destination fields (rt, rd, $ra, …) with a binary select and carries the result plus a valid bit through STAGES pipeline registers (ID/EX → EX/MEM → MEM/WB). It applies load-use stall and branch flush bubbles, and produces per-stage hazard-match vectors for the forwarding and hazard units.

Parameters:
- WIDTH, 5, bit width of each candidate and each stored destination.
- NUM_IN, 3, number of candidate inputs (≥2).
- STAGES, 3, number of pipeline stages carried (≥2).
- ZERO_SUPPRESS, 1, when 1 a destination equal to 0 never produces a hazard hit.
- SEL_W, $clog2(NUM_IN), select width; derived, never overridden.

Ports:
- Clk  in  1  rising-edge clock.
- Reset  in  1  synchronous, active-high reset.
- in_flat  in  NUM_IN*WIDTH  candidates; candidate i is bits [i*WIDTH +: WIDTH].
- sel  in  SEL_W  candidate index.
- in_vld  in  1  the instruction in ID writes a register.
- stall  in  1  load-use stall from the hazard unit.
- flush  in  1  branch/jump flush.
- src_a  in  WIDTH  rs of the instruction in ID.
- src_b  in  WIDTH  rt of the instruction in ID.
- dst_q  out  STAGES*WIDTH  registered destination per stage; stage k is [k*WIDTH +: WIDTH].
- vld_q  out  STAGES  registered valid per stage.
- wb_dst  out  WIDTH  equals stage STAGES-1 destination.
- wb_vld  out  1  equals vld_q[STAGES-1].
- hit_a  out  STAGES  per-stage match against src_a.
- hit_b  out  STAGES  per-stage match against src_b.
- bad_sel  out  1  sticky flag: sel ≥ NUM_IN was accepted.

Behaviour:
- Clock and reset: one clock, Clk. Reset is synchronous and active-high. At any edge with Reset=1, all dst_q and vld_q are 0 and bad_sel is 0, so wb_dst=0, wb_vld=0, hit_a=0, hit_b=0. Reset mid-operation discards every in-flight entry.
- Mux: mux_out = candidate[sel]. If sel ≥ NUM_IN, mux_out = candidate 0.
- Priority per edge: Reset > flush > stall > normal.
- Normal:
  - Stage 0 ← {mux_out, in_vld}.
  - Stage k ← stage k-1 for k ≥ 1.
  - Latency: ID issue at edge N appears on wb_dst/wb_vld after edge N+STAGES-1, i.e. STAGES edges from entry.
- Stall (flush=0):
  - Stage 0 holds its value.
  - Stage 1 ← bubble (dst 0, vld 0).
  - Stages ≥2 shift normally.
  - New input is not captured.
- Flush:
  - Stage 0 ← bubble regardless of in_vld.
  - Stages ≥1 shift normally. If stall is also 1, stage 1 also ← bubble.
- A bubble always has dst=0, vld=0.
- Hazard (combinational from registers and src inputs): hit_a[k] = vld_q[k] & (dst_k == src_a) & ~(ZERO_SUPPRESS & dst_k == 0). hit_b is the same with src_b. Multiple bits may be set; the consumer prioritises the lowest k.
- bad_sel: set on an edge where in_vld=1, sel ≥ NUM_IN and the input is captured (no stall, no flush). Cleared only by Reset.
- Power-of-two NUM_IN: bad_sel is constant 0.

Optional Feature:
- Macro: DEST_SEL_PERF_CNT_EN.
- Defined:
  - Adds outputs wb_cnt [15:0] and bubble_cnt [15:0], both reset to 0.
  - wb_cnt increments on each edge where wb_vld=1.
  - bubble_cnt increments on each edge where a bubble is inserted by stall or flush; one count per edge even if both are asserted.
  - Both saturate at 16'hFFFF.
- Undefined: neither port nor counter exists; all other behaviour is identical.

Decomposition:
- Shared package dest_sel_pkg holds:
  - REG_W=5
  - REG_ZERO=5'd0
  - REG_RA=5'd31
  - DSEL_RT=0, DSEL_RD=1, DSEL_RA=2 select encodings
- Sub-module dest_sel_mux: purely combinational NUM_IN×WIDTH mux with out-of-range detect. The top instantiates it once and owns all sequential state.

Test Plan:
- Reset then issue: candidates rt=5'd8, rd=5'd9, ra=5'd31, sel=1, in_vld=1 for one cycle → wb_dst=9, wb_vld=1 exactly 3 edges later for one cycle; all other cycles wb_vld=0.
- Stall: issue sel=0 (dst 8), then assert stall for 2 cycles → vld_q[1]=0 during the stall; entry leaves stage 0 after stall drops; wb_dst=8 appears 2 cycles later than unstalled.
- Flush with stall: flush=1, stall=1, in_vld=1 in the same cycle → vld_q[0]=0 and vld_q[1]=0 next cycle; the prior stage-1 entry still reaches wb.
- Hazard: stage 1 holds dst 8 valid, src_a=8, src_b=0; then a stage holds dst 0 valid with src_b=0 → hit_a=3'b010, hit_b=0 (ZERO_SUPPRESS=1).
- Bad select: NUM_IN=3, sel=3, in_vld=1, candidate0=5'd4 → stage 0 dst=4, bad_sel=1 and stays 1 until Reset.
- Perf counters (DEST_SEL_PERF_CNT_EN defined): 70000 consecutive valid issues → wb_cnt=16'hFFFF; 5 stall cycles → bubble_cnt=5.
